// File: rtl/fc_argmax_if.sv
// fc_argmax_if: score stream in, class decision out, for the argmax decision stage
interface fc_argmax_if #(
  parameter int DATA_WIDTH = 12
) ();
  logic                         valid_in;
  logic signed [DATA_WIDTH-1:0] data_in;
  logic        [3:0]            decision;
  logic signed [DATA_WIDTH-1:0] max_score;
  logic                         valid_out;
  logic        [15:0]           frame_cnt;
  modport master (
    output valid_in, data_in,
    input  decision, max_score, valid_out, frame_cnt
  );
  modport slave (
    input  valid_in, data_in,
    output decision, max_score, valid_out, frame_cnt
  );
endinterface

// File: rtl/fc_argmax_decision.sv
// fc_argmax_decision: running signed argmax over NUM_CLASS serial scores per frame
module fc_argmax_decision #(
  parameter int NUM_CLASS  = 10,
  parameter int DATA_WIDTH = 12
) (
  input logic        clk,
  input logic        rst_n,
  fc_argmax_if.slave bus
);
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t                       state_q, state_d;
  logic        [3:0]            idx_q, idx_d;
  logic signed [DATA_WIDTH-1:0] run_max_q, run_max_d;
  logic        [3:0]            run_idx_q, run_idx_d;
  logic        [3:0]            decision_q, decision_d;
  logic signed [DATA_WIDTH-1:0] max_score_q, max_score_d;
  logic                         valid_out_q, valid_out_d;
  logic        [15:0]           frame_cnt_q, frame_cnt_d;
  logic                         take;
  logic signed [DATA_WIDTH-1:0] win_max;
  logic        [3:0]            win_idx;
  logic                         last;
  // strict compare so the lowest index among equal maxima is kept
  assign take    = bus.data_in > run_max_q;
  assign win_max = take ? bus.data_in : run_max_q;
  assign win_idx = take ? idx_q : run_idx_q;
  assign last    = idx_q == 4'(NUM_CLASS - 1);
  // next state: score 0 loads unconditionally, later scores compete, the last one publishes
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    run_max_d   = run_max_q;
    run_idx_d   = run_idx_q;
    decision_d  = decision_q;
    max_score_d = max_score_q;
    valid_out_d = 1'b0;
    frame_cnt_d = frame_cnt_q;
    if (bus.valid_in && state_q == IDLE) begin
      run_max_d = bus.data_in;
      run_idx_d = 4'd0;
      idx_d     = 4'd1;
      state_d   = ACCUM;
    end else if (bus.valid_in) begin
      run_max_d = win_max;
      run_idx_d = win_idx;
      idx_d     = last ? 4'd0 : idx_q + 4'd1;
      state_d   = last ? IDLE : ACCUM;
      if (last) begin
        decision_d  = win_idx;
        max_score_d = win_max;
        valid_out_d = 1'b1;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
    end
  end
  // state and output registers; reset discards any partial frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      run_max_q   <= '0;
      run_idx_q   <= '0;
      decision_q  <= '0;
      max_score_q <= '0;
      valid_out_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      run_max_q   <= run_max_d;
      run_idx_q   <= run_idx_d;
      decision_q  <= decision_d;
      max_score_q <= max_score_d;
      valid_out_q <= valid_out_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end
  assign bus.decision  = decision_q;
  assign bus.max_score = max_score_q;
  assign bus.valid_out = valid_out_q;
  assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_fc_argmax_decision.sv
// tb_fc_argmax_decision: randomized per-cycle scoreboard against a frame-level argmax model
module tb_fc_argmax_decision;
  localparam int NC = 10;
  localparam int DW = 12;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int frame[$];
  logic               exp_valid = 1'b0;
  logic [3:0]         exp_dec = '0;
  logic signed [DW-1:0] exp_max = '0;
  logic [15:0]        exp_cnt = '0;
  fc_argmax_if #(.DATA_WIDTH(DW)) bus ();
  fc_argmax_decision #(.NUM_CLASS(NC), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  // index of the first maximum of a complete frame
  function automatic int argmax(input int q[$]);
    int best = 0;
    for (int i = 1; i < q.size(); i++) if (q[i] > q[best]) best = i;
    return best;
  endfunction
  function automatic int rnd_score();
    logic signed [DW-1:0] t;
    t = DW'($urandom);
    return int'(t);
  endfunction
  // check outputs from the previous edge, then drive the next cycle and advance the model
  task automatic step(input logic r, input logic v, input int d, input string tag);
    int b;
    @(negedge clk);
    checks += 4;
    if (bus.valid_out !== exp_valid) begin
      failures++;
      $display("FAIL %s valid_out got=%0b exp=%0b t=%0t", tag, bus.valid_out, exp_valid, $time);
    end
    if (bus.decision !== exp_dec) begin
      failures++;
      $display("FAIL %s decision got=%0d exp=%0d t=%0t", tag, bus.decision, exp_dec, $time);
    end
    if (bus.max_score !== exp_max) begin
      failures++;
      $display("FAIL %s max_score got=%0d exp=%0d t=%0t", tag, bus.max_score, exp_max, $time);
    end
    if (bus.frame_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL %s frame_cnt got=%0d exp=%0d t=%0t", tag, bus.frame_cnt, exp_cnt, $time);
    end
    rst_n = r;
    bus.valid_in = v;
    bus.data_in = DW'(d);
    exp_valid = 1'b0;
    if (!r) begin
      frame.delete();
      exp_dec = '0;
      exp_max = '0;
      exp_cnt = '0;
    end else if (v) begin
      frame.push_back(d);
      if (frame.size() == NC) begin
        b = argmax(frame);
        exp_dec = 4'(b);
        exp_max = DW'(frame[b]);
        exp_cnt = exp_cnt + 16'd1;
        exp_valid = 1'b1;
        frame.delete();
      end
    end
  endtask
  task automatic play(input int q[$], input int maxgap, input string tag);
    foreach (q[i]) begin
      repeat ($urandom_range(0, maxgap)) step(1'b1, 1'b0, rnd_score(), tag);
      step(1'b1, 1'b1, q[i], tag);
    end
    repeat (2) step(1'b1, 1'b0, 0, tag);
  endtask
  task automatic test_reset();
    step(1'b0, 1'b1, 77, "reset");
    step(1'b1, 1'b0, 0, "reset");
    step(1'b1, 1'b0, 0, "reset");
  endtask
  task automatic test_basic();
    play('{-5, 3, 100, 7, -128, 0, 99, 100, 2, 1}, 0, "basic");
  endtask
  task automatic test_negative();
    play('{-2048, -300, -1, -1, -9, -2047, -50, -2, -3, -4}, 0, "negative");
  endtask
  task automatic test_gaps();
    repeat (3) play('{-5, 3, 100, 7, -128, 0, 99, 100, 2, 1}, 3, "gaps");
  endtask
  task automatic test_back_to_back();
    int q[$];
    q = '{-5, 3, 100, 7, -128, 0, 99, 100, 2, 1};
    for (int i = 0; i < NC - 1; i++) q.push_back(int'($urandom_range(0, 2097)) - 2048);
    q.push_back(50);
    play(q, 0, "b2b");
  endtask
  task automatic test_reset_mid();
    int q[$];
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1000 + i, "midreset");
    step(1'b0, 1'b1, 2000, "midreset");
    for (int i = 0; i < NC; i++) q.push_back(i == 4 ? 500 : int'($urandom_range(0, 2547)) - 2048);
    play(q, 1, "midreset");
  endtask
  task automatic test_wrap();
    int q[$];
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFE;
    #1 release dut.frame_cnt_q;
    exp_cnt = 16'hFFFE;
    for (int i = 0; i < 2 * NC; i++) q.push_back(rnd_score());
    play(q, 1, "wrap");
  endtask
  task automatic test_random();
    int q[$];
    for (int f = 0; f < 30; f++) begin
      q.delete();
      for (int i = 0; i < NC; i++) q.push_back(f % 2 ? int'($urandom_range(0, 3)) - 2 : rnd_score());
      play(q, f % 3, "random");
    end
  endtask
  initial begin
    bus.valid_in = 1'b0;
    bus.data_in = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_negative();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
